// File: rtl/video_timing_gen.sv
// Raster timing generator: h/v counters, sync/de/coordinate outputs with a
// shadowed, validated timing configuration applied at frame boundaries.
module video_timing_gen #(
  parameter int unsigned W      = 12,
  parameter int unsigned FCNT_W = 10,
  parameter int unsigned DLY    = 0
) (
  input  logic              I_pxl_clk,
  input  logic              I_rst,
  input  logic              I_en,
  input  logic              I_cfg_load,
  input  logic [W-1:0]      I_h_total,
  input  logic [W-1:0]      I_h_sync,
  input  logic [W-1:0]      I_h_bporch,
  input  logic [W-1:0]      I_h_res,
  input  logic [W-1:0]      I_v_total,
  input  logic [W-1:0]      I_v_sync,
  input  logic [W-1:0]      I_v_bporch,
  input  logic [W-1:0]      I_v_res,
  input  logic              I_hs_pol,
  input  logic              I_vs_pol,
  output logic              O_de,
  output logic              O_hs,
  output logic              O_vs,
  output logic [W-1:0]      O_x,
  output logic [W-1:0]      O_y,
  output logic              O_sof,
  output logic              O_cfg_pending,
  output logic              O_cfg_err,
  output logic [FCNT_W-1:0] O_fcnt
);

  localparam int unsigned SW       = W + 2;
  localparam int unsigned PW       = 4 + 2 * W + FCNT_W;
  localparam int unsigned PIPE_W   = (DLY + 1) * PW;
  localparam int unsigned LAST_SOF = PIPE_W - 4;

  typedef struct packed {
    logic [W-1:0] h_total;
    logic [W-1:0] h_sync;
    logic [W-1:0] h_bporch;
    logic [W-1:0] h_res;
    logic [W-1:0] v_total;
    logic [W-1:0] v_sync;
    logic [W-1:0] v_bporch;
    logic [W-1:0] v_res;
  } timing_t;

  timing_t           w_in;
  timing_t           r_act;
  timing_t           r_pend;
  logic              r_pend_vld;
  logic              r_cfg_err;
  logic [W-1:0]      r_h_cnt;
  logic [W-1:0]      r_v_cnt;
  logic [FCNT_W-1:0] r_fcnt;
  logic [PIPE_W-1:0] r_pipe;

  logic              w_load_ok;
  logic              w_h_last;
  logic              w_v_last;
  logic              w_frame_wrap;
  logic [SW-1:0]     w_h_start;
  logic [SW-1:0]     w_h_stop;
  logic [SW-1:0]     w_v_start;
  logic [SW-1:0]     w_v_stop;
  logic              w_h_act;
  logic              w_v_act;
  logic              w_de;
  logic [W-1:0]      w_x;
  logic [W-1:0]      w_y;
  logic [PW-1:0]     w_stage0;
  logic [PW-1:0]     w_idle;
  logic [PW-1:0]     w_out;

  function automatic logic [SW-1:0] ext(input logic [W-1:0] a);
    return SW'(a);
  endfunction

  assign w_in = {I_h_total, I_h_sync, I_h_bporch, I_h_res,
                 I_v_total, I_v_sync, I_v_bporch, I_v_res};

  // Widened sums keep an overflowing configuration from looking valid.
  assign w_load_ok = (I_h_total >= W'(2)) && (I_v_total >= W'(2)) &&
                     (ext(I_h_sync) + ext(I_h_bporch) + ext(I_h_res) <= ext(I_h_total)) &&
                     (ext(I_v_sync) + ext(I_v_bporch) + ext(I_v_res) <= ext(I_v_total));

  assign w_h_last     = (ext(r_h_cnt) + SW'(1)) >= ext(r_act.h_total);
  assign w_v_last     = (ext(r_v_cnt) + SW'(1)) >= ext(r_act.v_total);
  assign w_frame_wrap = I_en && w_h_last && w_v_last;

  assign w_h_start = ext(r_act.h_sync) + ext(r_act.h_bporch);
  assign w_h_stop  = w_h_start + ext(r_act.h_res);
  assign w_v_start = ext(r_act.v_sync) + ext(r_act.v_bporch);
  assign w_v_stop  = w_v_start + ext(r_act.v_res);
  assign w_h_act   = (ext(r_h_cnt) >= w_h_start) && (ext(r_h_cnt) < w_h_stop);
  assign w_v_act   = (ext(r_v_cnt) >= w_v_start) && (ext(r_v_cnt) < w_v_stop);
  assign w_de      = w_h_act && w_v_act;
  assign w_x       = w_de ? W'(ext(r_h_cnt) - w_h_start) : '0;
  assign w_y       = w_de ? W'(ext(r_v_cnt) - w_v_start) : '0;

  assign w_stage0 = {w_de,
                     (r_h_cnt < r_act.h_sync) ~^ I_hs_pol,
                     (r_v_cnt < r_act.v_sync) ~^ I_vs_pol,
                     (r_h_cnt == '0) && (r_v_cnt == '0),
                     w_x, w_y, r_fcnt};
  assign w_idle   = {1'b0, ~I_hs_pol, ~I_vs_pol, 1'b0, (PW - 4)'(0)};

  // Pixel/line counters and frame counter.
  always_ff @(posedge I_pxl_clk) begin
    if (I_rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
      r_fcnt  <= '0;
    end else if (I_en) begin
      if (w_h_last) begin
        r_h_cnt <= '0;
        if (w_v_last) begin
          r_v_cnt <= '0;
          r_fcnt  <= r_fcnt + FCNT_W'(1);
        end else begin
          r_v_cnt <= r_v_cnt + W'(1);
        end
      end else begin
        r_h_cnt <= r_h_cnt + W'(1);
      end
    end
  end

  // Shadow configuration: apply old pending set at wrap, then capture any new load.
  always_ff @(posedge I_pxl_clk) begin
    if (I_rst) begin
      r_act      <= w_in;
      r_pend     <= w_in;
      r_pend_vld <= 1'b0;
      r_cfg_err  <= 1'b0;
    end else begin
      r_cfg_err <= I_cfg_load && !w_load_ok;
      if (w_frame_wrap && r_pend_vld) begin
        r_act <= r_pend;
      end
      if (I_cfg_load && w_load_ok) begin
        r_pend     <= w_in;
        r_pend_vld <= 1'b1;
      end else if (w_frame_wrap) begin
        r_pend_vld <= 1'b0;
      end
    end
  end

  // Output pipeline; the newest stage sits in the low bits.
  always_ff @(posedge I_pxl_clk) begin
    if (I_rst) begin
      r_pipe <= {(DLY + 1){w_idle}};
    end else if (I_en) begin
      r_pipe <= PIPE_W'({r_pipe, w_stage0});
    end else begin
      r_pipe[LAST_SOF] <= 1'b0;
    end
  end

  assign w_out         = r_pipe[PIPE_W-1 -: PW];
  assign O_de          = w_out[PW-1];
  assign O_hs          = w_out[PW-2];
  assign O_vs          = w_out[PW-3];
  assign O_sof         = w_out[PW-4];
  assign O_x           = w_out[FCNT_W+2*W-1 -: W];
  assign O_y           = w_out[FCNT_W+W-1 -: W];
  assign O_fcnt        = w_out[FCNT_W-1:0];
  assign O_cfg_pending = r_pend_vld;
  assign O_cfg_err     = r_cfg_err;

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- W, 12, width of every timing field and of the x/y counters.
- FCNT_W, 10, frame counter width.
- DLY, 0, extra output pipeline stages, legal range 0..4.
REQ-002 Ports, one per line: name, direction, width, meaning.
- I_pxl_clk, in, 1, pixel clock; the only clock.
- I_rst, in, 1, synchronous reset, active-high.
- I_en, in, 1, count enable.
- I_cfg_load, in, 1, single-cycle pulse that captures the timing inputs.
- I_h_total, I_h_sync, I_h_bporch, I_h_res, in, W each, horizontal timing.
- I_v_total, I_v_sync, I_v_bporch, I_v_res, in, W each, vertical timing.
- I_hs_pol, I_vs_pol, in, 1 each, sync polarity; 1 = active-high.
- O_de, O_hs, O_vs, out, 1 each, video timing outputs.
- O_x, O_y, out, W each, active-area pixel coordinates.
- O_sof, out, 1, start-of-frame pulse.
- O_cfg_pending, out, 1, a captured configuration is waiting to be applied.
- O_cfg_err, out, 1, the last load was rejected.
- O_fcnt, out, FCNT_W, frame counter.

Function
REQ-003 Internal counters: h_cnt runs 0..h_total-1; v_cnt advances when h_cnt wraps and runs 0..v_total-1.
REQ-004 Wrap compares use >= (h_cnt >= h_total-1, and likewise for v_cnt), so a shrunken total can never strand a counter.
REQ-005 When I_en=0, the counters, frame counter and output pipeline hold their values; O_sof is forced to 0.
REQ-006 Raw hs = (h_cnt < h_sync); raw vs = (v_cnt < v_sync).
REQ-007 Raw h-active = h_sync+h_bporch <= h_cnt < h_sync+h_bporch+h_res; raw v-active is defined the same way on v_cnt; raw de = h-active AND v-active.
REQ-008 x = h_cnt-(h_sync+h_bporch) and y = v_cnt-(v_sync+v_bporch) while raw de=1; both are 0 otherwise.
REQ-009 Raw sof = (h_cnt==0 AND v_cnt==0).
REQ-010 Output polarity: O_hs = raw hs XNOR I_hs_pol; O_vs = raw vs XNOR I_vs_pol; polarity inputs are applied live, not shadowed.
REQ-011 Latency: O_de, O_hs, O_vs, O_x, O_y and O_sof all reflect counter state after exactly 1+DLY enabled cycles, mutually aligned.
REQ-012 O_fcnt increments by 1 on each enabled v_cnt wrap (0,0 reached) and wraps modulo 2^FCNT_W; it is updated coincident with O_sof rising.
REQ-013 Shadow configuration, capture: I_cfg_load=1 captures all eight timing inputs into pending registers and sets O_cfg_pending=1.
REQ-014 Shadow configuration, apply: on the enabled cycle where both counters wrap to 0, the active registers take the pending values and O_cfg_pending clears.
REQ-015 If I_cfg_load coincides with the wrap cycle, the previous pending set (if any) is applied, the new values are captured, and O_cfg_pending remains 1 for the next frame.
REQ-016 A second load before the apply overwrites the pending values (last load wins).
REQ-017 A load is rejected when any of these holds: h_total<2; v_total<2; h_sync+h_bporch+h_res > h_total; v_sync+v_bporch+v_res > v_total.
REQ-018 On rejection, the pending state is unchanged and O_cfg_err pulses 1 for exactly one cycle after the load.
REQ-019 Sums in REQ-007 and REQ-017 use W+2-bit arithmetic, so overflow cannot produce a false pass.
REQ-020 O_cfg_err and O_sof are single-cycle pulses.

Reset
REQ-021 I_rst=1 on a clock edge sets the following:
- h_cnt=0, v_cnt=0.
- O_fcnt=0, O_cfg_pending=0, O_cfg_err=0.
- O_de=0, O_sof=0, O_x=0, O_y=0.
- O_hs=~I_hs_pol and O_vs=~I_vs_pol (inactive levels).
- All pipeline stages are flushed to those same inactive values.
REQ-022 During reset, the active registers load the timing inputs directly; they are not checked, and a reset overrides any pending configuration.
REQ-023 After reset deasserts, the first enabled cycle counts from h_cnt=0, v_cnt=0; the first O_sof appears 1+DLY enabled cycles later.

Verification
Base timing for all scenarios: h 10/2/2/4, v 6/1/1/3, pol=1, DLY=0.
REQ-024 Release reset, hold I_en=1 for 60 cycles.
- Expected: O_sof at cycle 1 and again at cycle 61.
- Expected: O_de high for 12 cycles per frame, in 3 runs of 4 with O_x=0..3 and O_y=0..2.
- Expected: O_hs high 2 of every 10 cycles; O_vs high for the first 10 cycles of the frame.
REQ-025 Pulse I_cfg_load mid-frame with h_res=6, h_bporch=1, h_sync=1.
- Expected: O_cfg_pending=1 until the frame wraps.
- Expected: the next frame shows 6-cycle de runs; the current frame is unchanged.
REQ-026 Pulse I_cfg_load with h_total=10, h_sync=4, h_bporch=4, h_res=4 (sum 12 > 10).
- Expected: O_cfg_err=1 for one cycle; O_cfg_pending stays 0; timing is unchanged.
REQ-027 Deassert I_en for 7 cycles mid-line.
- Expected: all outputs and O_x are frozen.
- Expected: on re-enable, the sequence resumes with no lost or duplicated pixel.
REQ-028 DLY=3 with I_hs_pol=0.
- Expected: all outputs shift 3 cycles later than in REQ-024; O_hs is low during sync.
- Expected: a reset asserted mid-frame returns outputs to inactive values on the next edge.
REQ-029 FCNT_W=2, run 5 frames.
- Expected: O_fcnt sequence is 1,2,3,0,1.
